// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a single shared memory
//             port. Each transaction takes three cycles (IDLE -> ACCESS ->
//             RESP). The winner's command is latched on entry to ACCESS, so
//             requester inputs are ignored once a transaction has started.
//  Ports    :
//    clk                     single clock, rising edge
//    reset                   asynchronous, active-low reset
//    c_req/c_we/c_adr/c_wdata  core requester (port 0) command
//    c_rdata/c_ack           core read data / one-cycle completion pulse
//    d_req/d_we/d_adr/d_wdata  loader/debug requester (port 1) command
//    d_rdata/d_ack           loader read data / one-cycle completion pulse
//    MemWrite/Adr/WriteData  shared memory command (driven from latched regs)
//    ReadData                shared memory read data, sampled at end of ACCESS
//    busy                    high whenever a transaction is in progress
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // core requester (port 0)
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  // loader/debug requester (port 1)
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  // shared memory port
  output logic          MemWrite,
  output logic [AW-1:0] Adr,
  output logic [DW-1:0] WriteData,
  input  logic [DW-1:0] ReadData,
  // status
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_gnt;       // 0 = core, 1 = loader
  logic          r_last_gnt;  // most recent winner, drives round-robin
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;

  logic          w_winner;
  logic          w_start;

  // --------------------------------------------------------------------------
  // Winner selection: a lone requester wins outright; under contention the
  // port that did not win last time is chosen, which bounds any wait to one
  // intervening transaction.
  // --------------------------------------------------------------------------
  always_comb begin
    w_winner = 1'b0;
    if (c_req && d_req) begin
      w_winner = ~r_last_gnt;
    end else if (d_req) begin
      w_winner = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs. MemWrite, the acks and busy are
  // decoded straight from the state register so that an asynchronous reset
  // drops them immediately rather than one edge later.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    MemWrite = 1'b0;
    c_ack    = 1'b0;
    d_ack    = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (c_req || d_req) begin
          w_next  = ACCESS;
          w_start = 1'b1;
        end
      end
      ACCESS: begin
        MemWrite = r_we;
        w_next   = RESP;
      end
      RESP: begin
        c_ack  = ~r_gnt;
        d_ack  = r_gnt;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch and read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;   // core wins the first contention after reset
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_start) begin
        r_gnt      <= w_winner;
        r_last_gnt <= w_winner;
        r_we       <= w_winner ? d_we    : c_we;
        r_adr      <= w_winner ? d_adr   : c_adr;
        r_wdata    <= w_winner ? d_wdata : c_wdata;
      end
      // ReadData is valid during ACCESS; capture it on the way into RESP.
      // Writes leave both read-data registers untouched.
      if ((r_state == ACCESS) && !r_we) begin
        if (r_gnt) begin
          r_d_rdata <= ReadData;
        end else begin
          r_c_rdata <= ReadData;
        end
      end
    end
  end

  // The memory command always comes from the latched copy, so Adr and
  // WriteData never follow requester inputs and hold between transactions.
  assign Adr       = r_adr;
  assign WriteData = r_wdata;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire
